// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM state encoding and flag bit positions for alu_seq.
// Op 1100 (multiply) is only built when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

    localparam int unsigned OPW    = 4;
    localparam int unsigned NFLAGS = 4;

    localparam logic [OPW-1:0] OP_PASS = 4'b0000;
    localparam logic [OPW-1:0] OP_NOT  = 4'b0001;
    localparam logic [OPW-1:0] OP_ADD  = 4'b0010;
    localparam logic [OPW-1:0] OP_SUB  = 4'b0011;
    localparam logic [OPW-1:0] OP_AND  = 4'b0100;
    localparam logic [OPW-1:0] OP_OR   = 4'b0101;
    localparam logic [OPW-1:0] OP_NEGA = 4'b0110;
    localparam logic [OPW-1:0] OP_NEGB = 4'b0111;
    localparam logic [OPW-1:0] OP_SHL  = 4'b1000;
    localparam logic [OPW-1:0] OP_SHR  = 4'b1001;
    localparam logic [OPW-1:0] OP_SAR  = 4'b1010;
    localparam logic [OPW-1:0] OP_ROL  = 4'b1011;
    localparam logic [OPW-1:0] OP_MUL  = 4'b1100;

    localparam int unsigned FLG_ZERO  = 0;
    localparam int unsigned FLG_CARRY = 1;
    localparam int unsigned FLG_NEG   = 2;
    localparam int unsigned FLG_OVF   = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    // Ops 1000-1011 share the iterative shifter; the low two bits pick the kind.
    function automatic logic is_shift(input logic [OPW-1:0] op);
        return (op[OPW-1:OPW-2] == 2'b10);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: legacy ops 0000-0111 with flags.
// Any other op code yields y=0 with only the zero flag set.
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    input  logic [OPW-1:0]    i_op,
    output logic [WIDTH-1:0]  o_y_c,
    output logic [NFLAGS-1:0] o_flags_c
);

    localparam logic [WIDTH-1:0] MIN_SIGNED = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_nega;
    logic [WIDTH-1:0] w_negb;
    logic             w_carry;
    logic             w_ovf;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = i_a - i_b;
    assign w_nega = WIDTH'(0) - i_a;
    assign w_negb = WIDTH'(0) - i_b;

    always_comb begin
        o_y_c   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (i_op)
            OP_PASS: o_y_c = i_a;
            OP_NOT:  o_y_c = ~i_a;
            OP_ADD: begin
                o_y_c   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                o_y_c   = w_diff;
                w_carry = (i_a < i_b);
                w_ovf   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND:  o_y_c = i_a & i_b;
            OP_OR:   o_y_c = i_a | i_b;
            OP_NEGA: begin
                o_y_c   = w_nega;
                w_carry = |i_a;
                w_ovf   = (i_a == MIN_SIGNED);
            end
            OP_NEGB: begin
                o_y_c   = w_negb;
                w_carry = |i_b;
                w_ovf   = (i_b == MIN_SIGNED);
            end
            default: o_y_c = '0;
        endcase
    end

    always_comb begin
        o_flags_c            = '0;
        o_flags_c[FLG_ZERO]  = ~|o_y_c;
        o_flags_c[FLG_CARRY] = w_carry;
        o_flags_c[FLG_NEG]   = o_y_c[WIDTH-1];
        o_flags_c[FLG_OVF]   = w_ovf;
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake, iterative shift/rotate and,
// when ALU_SEQ_MUL_EN is defined, an iterative shift-add multiplier on op 1100.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op_alu,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNTW = $clog2(WIDTH + 1);

    state_t              r_state;
    logic [WIDTH-1:0]    r_y;
    logic [NFLAGS-1:0]   r_flags;
    logic                r_busy;
    logic                r_done;
    logic [WIDTH-1:0]    r_sh;
    logic [CNTW-1:0]     r_cnt;
    logic [1:0]          r_sop;

    logic [SHW-1:0]      w_k;
    logic                w_is_shift;
    logic                w_multi;
    logic                w_start_mul;
    logic [OPW-1:0]      w_core_op;
    logic [WIDTH-1:0]    w_core_y;
    logic [NFLAGS-1:0]   w_core_flags;
    logic [WIDTH-1:0]    w_sh_next;
    logic                w_sh_out;
    logic [WIDTH-1:0]    w_exec_y;
    logic                w_exec_carry;
    logic                w_exec_ovf;
    logic [NFLAGS-1:0]   w_exec_flags;

    assign w_k        = b[SHW-1:0];
    assign w_is_shift = is_shift(op_alu);
    // A zero-count shift completes immediately as a pass of a.
    assign w_core_op  = w_is_shift ? OP_PASS : op_alu;

`ifdef ALU_SEQ_MUL_EN
    logic                r_mul;
    logic [WIDTH-1:0]    r_mcand;
    logic [2*WIDTH-1:0]  r_acc;
    logic [WIDTH:0]      w_msum;
    logic [2*WIDTH-1:0]  w_acc_next;

    assign w_start_mul = (op_alu == OP_MUL);
    // Accumulator holds {partial product, remaining multiplier}; one bit retires per step.
    assign w_msum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_next  = {w_msum, r_acc[WIDTH-1:1]};
`else
    assign w_start_mul = 1'b0;
`endif

    assign w_multi = (w_is_shift && (w_k != '0)) || w_start_mul;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_a       (a),
        .i_b       (b),
        .i_op      (w_core_op),
        .o_y_c     (w_core_y),
        .o_flags_c (w_core_flags)
    );

    // One-bit shift/rotate step of the working operand.
    always_comb begin
        w_sh_next = r_sh;
        w_sh_out  = 1'b0;
        case (r_sop)
            OP_SHL[1:0]: begin
                w_sh_next = {r_sh[WIDTH-2:0], 1'b0};
                w_sh_out  = r_sh[WIDTH-1];
            end
            OP_SHR[1:0]: begin
                w_sh_next = {1'b0, r_sh[WIDTH-1:1]};
                w_sh_out  = r_sh[0];
            end
            OP_SAR[1:0]: begin
                w_sh_next = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
                w_sh_out  = r_sh[0];
            end
            default: begin
                w_sh_next = {r_sh[WIDTH-2:0], r_sh[WIDTH-1]};
                w_sh_out  = r_sh[WIDTH-1];
            end
        endcase
    end

    always_comb begin
        w_exec_y     = w_sh_next;
        w_exec_carry = w_sh_out;
        w_exec_ovf   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        if (r_mul) begin
            w_exec_y     = w_acc_next[WIDTH-1:0];
            w_exec_carry = |w_acc_next[2*WIDTH-1:WIDTH];
            w_exec_ovf   = |w_acc_next[2*WIDTH-1:WIDTH];
        end
`endif
        w_exec_flags            = '0;
        w_exec_flags[FLG_ZERO]  = ~|w_exec_y;
        w_exec_flags[FLG_CARRY] = w_exec_carry;
        w_exec_flags[FLG_NEG]   = w_exec_y[WIDTH-1];
        w_exec_flags[FLG_OVF]   = w_exec_ovf;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_y     <= '0;
            r_flags <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_sop   <= '0;
`ifdef ALU_SEQ_MUL_EN
            r_mul   <= 1'b0;
            r_mcand <= '0;
            r_acc   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_multi) begin
                            r_state <= ST_EXEC;
                            r_busy  <= 1'b1;
                            r_sh    <= a;
                            r_sop   <= op_alu[1:0];
                            r_cnt   <= w_start_mul ? CNTW'(WIDTH) : CNTW'(w_k);
`ifdef ALU_SEQ_MUL_EN
                            r_mul   <= w_start_mul;
                            r_mcand <= a;
                            r_acc   <= {WIDTH'(0), b};
`endif
                        end else begin
                            r_y     <= w_core_y;
                            r_flags <= w_core_flags;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    r_sh  <= w_sh_next;
                    r_cnt <= r_cnt - CNTW'(1);
`ifdef ALU_SEQ_MUL_EN
                    r_acc <= w_acc_next;
`endif
                    if (r_cnt == CNTW'(1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_y     <= w_exec_y;
                        r_flags <= w_exec_flags;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign y        = r_y;
    assign zero     = r_flags[FLG_ZERO];
    assign carry    = r_flags[FLG_CARRY];
    assign negative = r_flags[FLG_NEG];
    assign overflow = r_flags[FLG_OVF];
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: 8-bit and 16-bit instances sharing clock and reset.
// Multiply expectations follow ALU_SEQ_MUL_EN as set for the build.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk;
    logic        reset_n;

    logic        start8;
    logic [7:0]  a8, b8, y8;
    logic [3:0]  op8;
    logic        zero8, carry8, neg8, ovf8, busy8, done8;

    logic        start16;
    logic [15:0] a16, b16, y16;
    logic [3:0]  op16;
    logic        zero16, carry16, neg16, ovf16, busy16, done16;

    int n_assert;
    int n_fail;
    int lat;
    int nbusy;
    int ndone;

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8), .op_alu(op8),
        .y(y8), .zero(zero8), .carry(carry8), .negative(neg8), .overflow(ovf8),
        .busy(busy8), .done(done8)
    );

    alu_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .a(a16), .b(b16), .op_alu(op16),
        .y(y16), .zero(zero16), .carry(carry16), .negative(neg16), .overflow(ovf16),
        .busy(busy16), .done(done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Flag vector order for checks: {zero, carry, negative, overflow}.
    function automatic logic [31:0] flags8();
        return {28'd0, zero8, carry8, neg8, ovf8};
    endfunction

    function automatic logic [31:0] flags16();
        return {28'd0, zero16, carry16, neg16, ovf16};
    endfunction

    // Launch one op, then count negedges until done (bounded) and busy samples.
    task automatic run(input bit w16, input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        if (w16) begin
            start16 = 1'b1; op16 = op; a16 = av; b16 = bv;
        end else begin
            start8 = 1'b1; op8 = op; a8 = av[7:0]; b8 = bv[7:0];
        end
        lat   = 0;
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start8  = 1'b0;
                start16 = 1'b0;
            end
            lat++;
            if (w16 ? busy16 : busy8) nbusy++;
            if (w16 ? done16 : done8) break;
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        start8   = 1'b0; a8  = '0; b8  = '0; op8  = '0;
        start16  = 1'b0; a16 = '0; b16 = '0; op16 = '0;

        #12;
        check("rst_y8",    {24'd0, y8}, 32'h00);
        check("rst_flags8", flags8(), 32'h0);
        check("rst_busy8", {31'd0, busy8}, 32'd0);
        check("rst_done8", {31'd0, done8}, 32'd0);
        check("rst_y16",   {16'd0, y16}, 32'h0000);

        @(negedge clk);
        reset_n = 1'b1;

        // Reset in the third cycle of a multiply aborts it without a done.
        @(negedge clk);
        start8 = 1'b1; op8 = OP_MUL; a8 = 8'h0D; b8 = 8'h0B;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_y",     {24'd0, y8}, 32'h00);
        check("abort_flags", flags8(), 32'h0);
        check("abort_busy",  {31'd0, busy8}, 32'd0);
        check("abort_done",  {31'd0, done8}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);

        run(1'b0, OP_ADD, 16'h05, 16'h03);
        check("add_lat", 32'(lat), 32'd1);
        check("add_y", {24'd0, y8}, 32'h08);
        check("add_flags", flags8(), 32'h0);

        run(1'b0, OP_ADD, 16'h7F, 16'h01);
        check("addovf_y", {24'd0, y8}, 32'h80);
        check("addovf_flags", flags8(), 32'h3);

        run(1'b0, OP_SUB, 16'h03, 16'h05);
        check("subb_y", {24'd0, y8}, 32'hFE);
        check("subb_flags", flags8(), 32'h6);

        run(1'b0, OP_SUB, 16'h22, 16'h22);
        check("subz_y", {24'd0, y8}, 32'h00);
        check("subz_flags", flags8(), 32'h8);

        run(1'b0, OP_NOT, 16'h0F, 16'h00);
        check("not_y", {24'd0, y8}, 32'hF0);
        check("not_flags", flags8(), 32'h2);

        run(1'b0, OP_NEGB, 16'h00, 16'h80);
        check("negb_y", {24'd0, y8}, 32'h80);
        check("negb_flags", flags8(), 32'h7);

        run(1'b0, OP_NEGB, 16'h55, 16'h00);
        check("negb0_flags", flags8(), 32'h8);

        run(1'b0, OP_SHL, 16'h81, 16'h03);
        check("shl_lat", 32'(lat), 32'd4);
        check("shl_busy", 32'(nbusy), 32'd3);
        check("shl_y", {24'd0, y8}, 32'h08);
        check("shl_flags", flags8(), 32'h0);

        run(1'b0, OP_SAR, 16'h80, 16'h07);
        check("sar_lat", 32'(lat), 32'd8);
        check("sar_y", {24'd0, y8}, 32'hFF);
        check("sar_flags", flags8(), 32'h2);

        // Count bits are zero although b itself is not.
        run(1'b0, OP_SHR, 16'h5A, 16'h08);
        check("shr0_lat", 32'(lat), 32'd1);
        check("shr0_busy", 32'(nbusy), 32'd0);
        check("shr0_y", {24'd0, y8}, 32'h5A);
        check("shr0_flags", flags8(), 32'h0);

        run(1'b0, OP_MUL, 16'h10, 16'h10);
`ifdef ALU_SEQ_MUL_EN
        check("mul_lat", 32'(lat), 32'd9);
        check("mul_busy", 32'(nbusy), 32'd8);
        check("mul_y", {24'd0, y8}, 32'h00);
        check("mul_flags", flags8(), 32'hD);
        run(1'b0, OP_MUL, 16'h0D, 16'h0B);
        check("mul2_y", {24'd0, y8}, 32'h8F);
        check("mul2_flags", flags8(), 32'h2);
`else
        check("mul_lat", 32'(lat), 32'd1);
        check("mul_busy", 32'(nbusy), 32'd0);
        check("mul_y", {24'd0, y8}, 32'h00);
        check("mul_flags", flags8(), 32'h8);
`endif

        // Back-to-back single-cycle ops: done on consecutive cycles, result then held.
        @(negedge clk);
        start8 = 1'b1; op8 = OP_AND; a8 = 8'hF0; b8 = 8'h3C;
        @(negedge clk);
        check("b2b_and_done", {31'd0, done8}, 32'd1);
        check("b2b_and_y", {24'd0, y8}, 32'h30);
        op8 = OP_OR; a8 = 8'hF0; b8 = 8'h0F;
        @(negedge clk);
        check("b2b_or_done", {31'd0, done8}, 32'd1);
        check("b2b_or_y", {24'd0, y8}, 32'hFF);
        start8 = 1'b0;
        @(negedge clk);
        check("hold_done", {31'd0, done8}, 32'd0);
        check("hold_y", {24'd0, y8}, 32'hFF);

        // start held high through a rotate; only the first is taken, the one on done launches ADD.
        @(negedge clk);
        start8 = 1'b1; op8 = OP_ROL; a8 = 8'h96; b8 = 8'h05;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                op8 = OP_ADD; a8 = 8'h01; b8 = 8'h01;
            end
            lat++;
            if (done8) break;
        end
        check("rol_lat", 32'(lat), 32'd6);
        check("rol_y", {24'd0, y8}, 32'hD2);
        check("rol_flags", flags8(), 32'h2);
        @(negedge clk);
        start8 = 1'b0;
        check("after_rol_done", {31'd0, done8}, 32'd1);
        check("after_rol_y", {24'd0, y8}, 32'h02);
        @(negedge clk);
        check("after_rol_idle", {31'd0, done8}, 32'd0);

        run(1'b1, OP_NEGA, 16'h8000, 16'h0000);
        check("w16_nega_lat", 32'(lat), 32'd1);
        check("w16_nega_y", {16'd0, y16}, 32'h8000);
        check("w16_nega_flags", flags16(), 32'h7);

        run(1'b1, OP_SHR, 16'h8001, 16'h000F);
        check("w16_shr_lat", 32'(lat), 32'd16);
        check("w16_shr_y", {16'd0, y16}, 32'h0001);
        check("w16_shr_flags", flags16(), 32'h0);

        run(1'b1, 4'b1111, 16'h1234, 16'h5678);
        check("w16_rsv_lat", 32'(lat), 32'd1);
        check("w16_rsv_busy", 32'(nbusy), 32'd0);
        check("w16_rsv_y", {16'd0, y16}, 32'h0000);
        check("w16_rsv_flags", flags16(), 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
